// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore-FSM controller for a multicycle MIPS datapath (lw, sw,
//            R-type, beq, addi, j) driving mux selects, enables and ALUControl.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMRD    = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWR    = STATE_W'(5),
        S_EXECUTE  = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_ADDIEXEC = STATE_W'(9),
        S_ADDIWB   = STATE_W'(10),
        S_JUMP     = STATE_W'(11)
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;
    logic       w_funct_ok;
    logic [2:0] w_funct_ctl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_ctl = 3'b000;
        case (funct)
            6'b100000: w_funct_ctl = 3'b000;
            6'b100010: w_funct_ctl = 3'b001;
            6'b100100: w_funct_ctl = 3'b010;
            6'b100101: w_funct_ctl = 3'b011;
            6'b101010: w_funct_ctl = 3'b101;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = c_ALUOP_ADD;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_aluop = c_ALUOP_FUNCT;
                if (w_funct_ok) begin
                    w_next = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_aluop  = c_ALUOP_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            // Spare encodings fall back to FETCH with everything idle.
            default: w_next = S_FETCH;
        endcase

        case (w_aluop)
            c_ALUOP_SUB:   ALUControl = 3'b001;
            c_ALUOP_FUNCT: ALUControl = w_funct_ctl;
            default:       ALUControl = 3'b000;
        endcase

        PCEn = w_pcwrite | (w_branch & zero);

        // Reset silences the datapath immediately, aborting any in-flight write.
        if (reset) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            ALUControl = 3'b000;
            illegal    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-FSM controller for the multicycle MIPS datapath. It sits directly upstream of the ALU and drives its 3-bit ALUControl, plus every datapath mux select and write enable. It decodes opcode/funct from the instruction register and the ALU zero flag. Instruction classes: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

Parameters:
STATE_W, 4, width of the state register (12 states used).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU result == 0 flag
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register load enable
PCEn  out  1  PC load enable
RegDst  out  1  write register select: 0 = rt, 1 = rd
MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
RegWrite  out  1  register file write enable
ALUSrcA  out  1  srcA select: 0 = PC, 1 = regA
ALUSrcB  out  2  srcB select: 00 = regB, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
PCSrc  out  2  next PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
ALUControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  out  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- Single state register, updated on rising clk. All outputs are combinational decodes of the state, plus funct (EXECUTE only) and zero (BRANCH only).
- Reset: synchronous. The state is FETCH on the first edge after reset is sampled high.
  - While reset is high, all enables (MemWrite, IRWrite, PCEn, RegWrite) and illegal are forced 0.
  - While reset is high, all selects are 0 and ALUControl = 000.
  - Reset mid-instruction aborts the instruction with no write.
- Internal aluop: 00 = add, 01 = sub, 10 = use funct.
- Funct decode:
  - 100000 → 000 (add)
  - 100010 → 001 (sub)
  - 100100 → 010 (and)
  - 100101 → 011 (or)
  - 101010 → 101 (slt)
  - any other funct → ALUControl 000, illegal = 1.
- Per-state outputs (unlisted outputs = 0):
  - FETCH: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, add, PCSrc = 00, IRWrite = 1, PCWrite = 1 → DECODE.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, add.
    - Next state by opcode: 100011/101011 → MEMADR, 000000 → EXECUTE, 000100 → BRANCH, 001000 → ADDIEXEC, 000010 → JUMP.
    - Any other opcode → FETCH with illegal = 1 for that cycle.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, add → MEMRD if opcode = 100011, else MEMWR.
  - MEMRD: IorD = 1 → MEMWB.
  - MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1 → FETCH.
  - MEMWR: IorD = 1, MemWrite = 1 → FETCH.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00, aluop = 10 → ALUWB. On illegal funct → FETCH instead, with illegal = 1.
  - ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1 → FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, sub, PCSrc = 01, Branch = 1 → FETCH.
  - ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10, add → ADDIWB.
  - ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1 → FETCH.
  - JUMP: PCSrc = 10, PCWrite = 1 → FETCH.
- PCEn = PCWrite | (Branch & zero). PCEn is asserted in BRANCH only if zero = 1 in that same cycle.
- Cycle counts (FETCH to the next FETCH, exclusive):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - illegal opcode 2, illegal funct 3.
- Unreachable state encodings → FETCH on the next edge, all enables 0 in that cycle.
- opcode is sampled only in DECODE and MEMADR, and funct only in EXECUTE; both are ignored in all other states.

Test Plan:
- Reset held 3 cycles then released → all enables 0 during reset. First post-reset cycle: FETCH with IRWrite = 1, PCEn = 1, ALUSrcB = 01, ALUControl = 000.
- lw (opcode 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. IorD = 1 in MEMRD. RegWrite = 1 with MemtoReg = 1 and RegDst = 0 on cycle 5. Back to FETCH on cycle 6.
- R-type with funct 101010 → ALUControl = 101 in EXECUTE, then ALUWB with RegDst = 1 and RegWrite = 1. Repeat for funct 100010 → ALUControl = 001.
- beq (000100) with zero = 1 → PCEn = 1 and PCSrc = 01 in BRANCH. Repeat with zero = 0 → PCEn = 0. Both runs return to FETCH after 3 cycles.
- j (000010) → PCSrc = 10 and PCEn = 1 in JUMP. Opcode 111111 → illegal = 1 in DECODE, then FETCH, with RegWrite and MemWrite never asserted.
- sw (101011) with reset asserted during MEMADR → MemWrite never asserted. State is FETCH on the edge after reset.
